// File: rtl/host_rx_fifo_if.sv
// Host-to-target byte FIFO bundle: host valid/ready push side, show-ahead pop side
// toward the m68k glue, plus occupancy and sticky underflow status.
interface host_rx_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    TX_data;
  logic                TXE;
  logic                TX_read;
  logic [DEPTH_LOG2:0] level;
  logic                underflow;
  logic                clr_flags;

  modport master (
    output in_data, in_valid, TX_read, clr_flags,
    input  in_ready, TX_data, TXE, level, underflow
  );

  modport slave (
    input  in_data, in_valid, TX_read, clr_flags,
    output in_ready, TX_data, TXE, level, underflow
  );
endinterface

// File: rtl/host_rx_fifo.sv
// Byte FIFO feeding host bytes to the m68k glue. Show-ahead output register holds
// the head byte; a rising edge on TX_read pops one entry. Full/empty come from level.
module host_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input logic           clk,
  input logic           rstn,
  host_rx_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_rd_q;
  logic                  r_underflow;
  logic                  r_in_ready;
  logic [WIDTH-1:0]      r_tx_data;
  logic                  r_txe;

  logic                  w_push;
  logic                  w_pop_ev;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_uf_set;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [DEPTH_LOG2:0]   w_level_after_pop;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic [WIDTH-1:0]      w_head_nxt;
  logic                  w_underflow_nxt;

  // Next-state for pointers, level, head byte and underflow flag
  always_comb begin
    w_push            = bus.in_valid & r_in_ready;
    w_pop_ev          = bus.TX_read & ~r_rd_q;
    w_empty           = (r_level == LVL_ZERO);
    w_pop             = w_pop_ev & ~w_empty;
    w_uf_set          = w_pop_ev & w_empty;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_level_after_pop = r_level;
    w_level_nxt       = r_level;
    w_head_nxt        = r_tx_data;
    w_underflow_nxt   = r_underflow;

    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end

    if (w_pop) begin
      w_rd_ptr_nxt      = r_rd_ptr + PTR_ONE;
      w_level_after_pop = r_level - LVL_ONE;
    end else begin
      w_rd_ptr_nxt      = r_rd_ptr;
      w_level_after_pop = r_level;
    end

    if (w_push) begin
      w_level_nxt = w_level_after_pop + LVL_ONE;
    end else begin
      w_level_nxt = w_level_after_pop;
    end

    // A byte landing in an otherwise empty queue is not yet in r_mem: bypass it
    if (w_level_nxt == LVL_ZERO) begin
      w_head_nxt = r_tx_data;
    end else if (w_push && (w_level_after_pop == LVL_ZERO)) begin
      w_head_nxt = bus.in_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    if (w_uf_set) begin
      w_underflow_nxt = 1'b1;
    end else if (bus.clr_flags) begin
      w_underflow_nxt = 1'b0;
    end else begin
      w_underflow_nxt = r_underflow;
    end
  end

  // Storage write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr    <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr    <= {DEPTH_LOG2{1'b0}};
      r_level     <= LVL_ZERO;
      r_rd_q      <= 1'b0;
      r_underflow <= 1'b0;
      r_in_ready  <= 1'b0;
      r_tx_data   <= {WIDTH{1'b0}};
      r_txe       <= 1'b1;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_level     <= w_level_nxt;
      r_rd_q      <= bus.TX_read;
      r_underflow <= w_underflow_nxt;
      r_in_ready  <= (w_level_nxt != LVL_FULL);
      r_tx_data   <= w_head_nxt;
      r_txe       <= (w_level_nxt == LVL_ZERO);
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.TX_data   = r_tx_data;
  assign bus.TXE       = r_txe;
  assign bus.level     = r_level;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_host_rx_fifo.sv
// Bench for host_rx_fifo: directed scenarios then random traffic, all checked
// every cycle against a queue-based model of the FIFO rules.
module tb_host_rx_fifo;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  host_rx_fifo_if #(.WIDTH(8), .DEPTH_LOG2(4)) bus ();
  host_rx_fifo #(.WIDTH(8), .DEPTH_LOG2(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_q[$];
  logic       m_ready = 1'b0;
  logic       m_rdq   = 1'b0;
  logic       m_uf    = 1'b0;
  logic [7:0] m_head  = 8'h00;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply current inputs, advance the model, compare after the edge
  task automatic cycle();
    logic       s_rstn;
    logic       s_valid;
    logic       s_rd;
    logic       s_clr;
    logic [7:0] s_data;
    logic       ev;
    logic [7:0] dropped;
    s_rstn  = rstn;
    s_valid = bus.in_valid;
    s_rd    = bus.TX_read;
    s_clr   = bus.clr_flags;
    s_data  = bus.in_data;
    @(posedge clk);
    if (!s_rstn) begin
      m_q.delete();
      m_ready = 1'b0;
      m_rdq   = 1'b0;
      m_uf    = 1'b0;
      m_head  = 8'h00;
    end else begin
      ev = s_rd && !m_rdq;
      if (ev && (m_q.size() == 0)) begin
        m_uf = 1'b1;
      end else begin
        if (ev) dropped = m_q.pop_front();
        if (s_clr) m_uf = 1'b0;
      end
      if (s_valid && m_ready) m_q.push_back(s_data);
      m_rdq   = s_rd;
      m_ready = (m_q.size() < 16);
      if (m_q.size() > 0) m_head = m_q[0];
    end
    #1;
    chk_val("level", 32'(bus.level), 32'(m_q.size()));
    chk_val("TXE", 32'(bus.TXE), 32'(m_q.size() == 0));
    chk_val("in_ready", 32'(bus.in_ready), 32'(m_ready));
    chk_val("underflow", 32'(bus.underflow), 32'(m_uf));
    if ((m_q.size() > 0) || !s_rstn) chk_val("TX_data", 32'(bus.TX_data), 32'(m_head));
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic pulse_read();
    bus.TX_read = 1'b1;
    cycle();
    bus.TX_read = 1'b0;
    cycle();
  endtask

  initial begin
    rstn          = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.TX_read   = 1'b0;
    bus.clr_flags = 1'b0;

    // Reset and release
    cycles(3);
    chk_val("rst_txe", 32'(bus.TXE), 32'd1);
    chk_val("rst_data", 32'(bus.TX_data), 32'h00);
    chk_val("rst_ready", 32'(bus.in_ready), 32'd0);
    rstn = 1'b1;
    cycle();
    chk_val("rel_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back push and single pulse pop
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5; cycle();
    chk_val("first_head", 32'(bus.TX_data), 32'hA5);
    bus.in_data  = 8'h5A; cycle();
    bus.in_data  = 8'h3C; cycle();
    bus.in_valid = 1'b0;
    chk_val("lvl3", 32'(bus.level), 32'd3);
    pulse_read();
    chk_val("head_5a", 32'(bus.TX_data), 32'h5A);
    chk_val("lvl2", 32'(bus.level), 32'd2);

    // Held TX_read pops once
    bus.TX_read = 1'b1;
    cycles(10);
    chk_val("held_lvl", 32'(bus.level), 32'd1);
    chk_val("held_head", 32'(bus.TX_data), 32'h3C);
    bus.TX_read = 1'b0;
    cycle();
    pulse_read();
    chk_val("drained_txe", 32'(bus.TXE), 32'd1);

    // Fill, stall a 17th byte, pop once, drain in order with wrap
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'(i);
      cycle();
    end
    bus.in_data = 8'h10;
    cycles(2);
    chk_val("full_lvl", 32'(bus.level), 32'd16);
    chk_val("full_ready", 32'(bus.in_ready), 32'd0);
    bus.TX_read = 1'b1;
    cycle();
    chk_val("ready_after_pop", 32'(bus.in_ready), 32'd1);
    bus.TX_read = 1'b0;
    cycle();
    bus.in_valid = 1'b0;
    chk_val("refull_lvl", 32'(bus.level), 32'd16);
    chk_val("refull_head", 32'(bus.TX_data), 32'h01);
    for (int i = 1; i <= 16; i++) begin
      chk_val("drain_order", 32'(bus.TX_data), 32'(i));
      pulse_read();
    end
    chk_val("drain_empty", 32'(bus.TXE), 32'd1);

    // Underflow set, set-wins over clear, clear alone
    pulse_read();
    chk_val("uf_set", 32'(bus.underflow), 32'd1);
    chk_val("uf_lvl", 32'(bus.level), 32'd0);
    bus.TX_read   = 1'b1;
    bus.clr_flags = 1'b1;
    cycle();
    chk_val("uf_set_wins", 32'(bus.underflow), 32'd1);
    bus.TX_read = 1'b0;
    cycle();
    bus.clr_flags = 1'b0;
    chk_val("uf_clr", 32'(bus.underflow), 32'd0);

    // Reset mid-operation discards contents
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(8'h40 + i);
      cycle();
    end
    chk_val("lvl5", 32'(bus.level), 32'd5);
    bus.in_data = 8'h77;
    rstn = 1'b0;
    cycle();
    chk_val("mid_rst_lvl", 32'(bus.level), 32'd0);
    chk_val("mid_rst_txe", 32'(bus.TXE), 32'd1);
    rstn = 1'b1;
    bus.in_valid = 1'b0;
    cycle();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    cycle();
    bus.in_valid = 1'b0;
    chk_val("post_rst_head", 32'(bus.TX_data), 32'hC3);
    chk_val("post_rst_lvl", 32'(bus.level), 32'd1);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 4000; i++) begin
      bus.in_valid  = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 30));
      bus.in_data   = 8'($urandom);
      bus.TX_read   = ($urandom_range(0, 99) < 45);
      bus.clr_flags = ($urandom_range(0, 99) < 5);
      rstn          = ($urandom_range(0, 999) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
